// File: rtl/regwr_arbiter_pkg.sv
// regwr_arbiter_pkg: shared state encoding and default parameters for the register-bank write arbiter
package regwr_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  localparam int NREQ_DEF     = 4;
  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 64;
  localparam int LOCK_MAX_DEF = 8;
  localparam int XZR_IDX_DEF  = 31;
endpackage

// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if: requester handshake bundle plus the registered bank write port
interface regwr_arbiter_if import regwr_arbiter_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [IW-1:0]      lock_owner;
  logic               locked;
  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, lock_owner, locked
  );
  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, lock_owner, locked
  );
endinterface

// File: rtl/regwr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    j   = '0;
    idx = '0;
    any = 1'b0;
    // scan from the far end so the nearest request to ptr overwrites last
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin sharing of the register-bank write port with bounded lock bursts
module regwr_arbiter import regwr_arbiter_pkg::*; #(
  parameter int NREQ     = NREQ_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF,
  parameter int XZR_IDX  = XZR_IDX_DEF
) (
  input logic            clk,
  input logic            reset,
  regwr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, ptr_n, owner, owner_n, sel, pick_idx;
  logic [CW-1:0]   lock_cnt, cnt_n;
  logic [NREQ-1:0] pick_gnt, ready;
  logic            pick_any, xfer, enter, rel;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = bus.req_addr[g*AW +: AW];
    assign data_a[g] = bus.req_data[g*DW +: DW];
  end
  rr_pick #(.N(NREQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
  always_comb begin
    sel     = state == ST_LOCKED ? owner : pick_idx;
    ready   = !reset ? '0 : state == ST_LOCKED ? bus.req_valid & (NREQ'(1) << owner) : pick_gnt;
    xfer    = reset && (state == ST_LOCKED ? bus.req_valid[owner] : pick_any);
    enter   = state == ST_IDLE && xfer && bus.req_lock[sel];
    rel     = state == ST_LOCKED && ((xfer && !bus.req_lock[sel]) || lock_cnt == CW'(LOCK_MAX));
    state_n = enter ? ST_LOCKED : rel ? ST_IDLE : state;
    ptr_n   = ((state == ST_IDLE && xfer) || rel) ? IW'((int'(sel) + 1) % NREQ) : rr_ptr;
    owner_n = enter ? sel : owner;
    // the lock budget drains every locked cycle, even when the owner is idle
    cnt_n   = enter ? CW'(1) : (state == ST_LOCKED && !rel) ? lock_cnt + CW'(1) : lock_cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      owner    <= owner_n;
      lock_cnt <= cnt_n;
      wr_en_q  <= xfer && addr_a[sel] != AW'(XZR_IDX);
      if (xfer) begin
        wr_addr_q <= addr_a[sel];
        wr_data_q <= data_a[sel];
      end
    end
  end
  assign bus.req_ready  = ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.lock_owner = owner;
  assign bus.locked     = state == ST_LOCKED;
endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: directed vector table, reset corner sequences and randomized traffic against a reference model
module tb_regwr_arbiter;
  localparam int LOCK_MAX = 8;
  typedef struct {
    logic [3:0] v;
    logic [3:0] lk;
    logic [3:0] rdy;
    logic [4:0] a2;
    logic       wen;
    logic [4:0] wa;
    logic       lkd;
  } vec_t;
  logic clk;
  logic reset;
  regwr_arbiter_if bus ();
  regwr_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [3:0]  v, lk, pend, r;
  logic [4:0]  a [4];
  logic [63:0] d [4];
  vec_t        tbl [23];
  int          m_ptr, m_owner, m_left;
  bit          m_locked;
  logic        e_wen;
  logic [4:0]  e_addr;
  logic [63:0] e_data;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive();
    bus.req_valid = v;
    bus.req_lock  = lk;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*5 +: 5]   = a[i];
      bus.req_data[i*64 +: 64] = d[i];
    end
  endtask
  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_left = 0; m_locked = 0;
    e_wen = 0; e_addr = '0; e_data = '0;
  endtask
  // who may transfer right now: the lock holder alone, else the nearest requester from the pointer
  function automatic logic [3:0] exp_ready();
    if (!reset) return 4'b0000;
    if (m_locked) return v[m_owner] ? 4'(1 << m_owner) : 4'b0000;
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
    return 4'b0000;
  endfunction
  task automatic model_update();
    logic [3:0] g;
    int w;
    g = exp_ready();
    w = -1;
    for (int i = 0; i < 4; i++) if (g[i]) w = i;
    if (!reset) begin
      model_reset();
      return;
    end
    if (w >= 0) begin
      e_wen = a[w] != 5'd31; e_addr = a[w]; e_data = d[w];
    end else e_wen = 0;
    if (!m_locked) begin
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        if (lk[w]) begin m_locked = 1; m_owner = w; m_left = LOCK_MAX - 1; end
      end
    end else if ((w >= 0 && !lk[w]) || m_left == 0) begin
      m_locked = 0; m_ptr = (m_owner + 1) % 4;
    end else m_left--;
  endtask
  task automatic check_all();
    chk("ready", 64'(bus.req_ready), 64'(exp_ready()));
    chk("wr_en", 64'(bus.wr_en), 64'(e_wen));
    chk("wr_addr", 64'(bus.wr_addr), 64'(e_addr));
    chk("wr_data", bus.wr_data, e_data);
    chk("locked", 64'(bus.locked), 64'(m_locked));
    if (m_locked) chk("lock_owner", 64'(bus.lock_owner), 64'(m_owner));
  endtask
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask
  initial begin
    tbl = '{
      '{4'b1111, 4'b0000, 4'b0001, 5'd3,  1'b0, 5'd0,  1'b0},
      '{4'b1111, 4'b0000, 4'b0010, 5'd3,  1'b1, 5'd1,  1'b0},
      '{4'b1111, 4'b0000, 4'b0100, 5'd3,  1'b1, 5'd2,  1'b0},
      '{4'b1111, 4'b0000, 4'b1000, 5'd3,  1'b1, 5'd3,  1'b0},
      '{4'b1111, 4'b0000, 4'b0001, 5'd3,  1'b1, 5'd4,  1'b0},
      '{4'b0100, 4'b0000, 4'b0100, 5'd31, 1'b1, 5'd1,  1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 5'd31, 1'b0, 5'd31, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 5'd31, 1'b0, 5'd31, 1'b0},
      '{4'b0010, 4'b0010, 4'b0010, 5'd3,  1'b0, 5'd31, 1'b0},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0010, 4'b0010, 5'd3,  1'b1, 5'd2,  1'b1},
      '{4'b1111, 4'b0000, 4'b0100, 5'd3,  1'b1, 5'd2,  1'b0},
      '{4'b1000, 4'b1000, 4'b1000, 5'd3,  1'b1, 5'd3,  1'b0},
      '{4'b1000, 4'b1000, 4'b1000, 5'd3,  1'b1, 5'd4,  1'b1},
      '{4'b1000, 4'b1000, 4'b1000, 5'd3,  1'b1, 5'd4,  1'b1},
      '{4'b1000, 4'b0000, 4'b1000, 5'd3,  1'b1, 5'd4,  1'b1},
      '{4'b1111, 4'b0000, 4'b0001, 5'd3,  1'b1, 5'd4,  1'b0}
    };
    reset = 1'b0;
    v = 4'b1111;
    lk = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(i + 1);
      d[i] = 64'hA0 + 64'(i);
    end
    drive();
    model_reset();
    #1;
    repeat (3) cycle();
    reset = 1'b1;
    for (int n = 0; n < 23; n++) begin
      v = tbl[n].v; lk = tbl[n].lk; a[2] = tbl[n].a2;
      drive();
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", n), 64'(bus.req_ready), 64'(tbl[n].rdy));
      chk($sformatf("tbl%0d_wr_en", n), 64'(bus.wr_en), 64'(tbl[n].wen));
      chk($sformatf("tbl%0d_wr_addr", n), 64'(bus.wr_addr), 64'(tbl[n].wa));
      chk($sformatf("tbl%0d_locked", n), 64'(bus.locked), 64'(tbl[n].lkd));
      check_all();
      @(posedge clk);
      model_update();
      #1;
    end
    v = 4'b0010; lk = 4'b0010;
    drive();
    repeat (2) cycle();
    @(negedge clk);
    chk("prerst_wr_en", 64'(bus.wr_en), 64'd1);
    chk("prerst_locked", 64'(bus.locked), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_locked", 64'(bus.locked), 64'd0);
    chk("rst_owner", 64'(bus.lock_owner), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b1;
    v = 4'b0000; lk = 4'b0000;
    drive();
    repeat (2) cycle();
    pend = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          v[i]  = $urandom_range(0, 99) < 60;
          lk[i] = $urandom_range(0, 99) < 30;
          a[i]  = 5'($urandom_range(0, 31));
          d[i]  = {$urandom, $urandom};
        end
      end
      drive();
      r = exp_ready();
      cycle();
      pend = v & ~r;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
